// File: rtl/debug_cmd_sequencer_pkg.sv
// debug_cmd_sequencer_pkg: opcodes, request encoding, FSM states and helpers shared with the debug receiver
package debug_cmd_sequencer_pkg;

  localparam int unsigned OPC_NOP     = 0;
  localparam int unsigned OPC_ADDR    = 1;
  localparam int unsigned OPC_LDATA   = 2;
  localparam int unsigned OPC_HDATA   = 3;
  localparam int unsigned OPC_PC      = 4;
  localparam int unsigned OPC_PC_LT   = 5;
  localparam int unsigned OPC_INST_LT = 6;

  localparam int unsigned N_WR_CMDS = 4;

  typedef enum logic [1:0] {
    REQ_WRITE      = 2'd0,
    REQ_RD_PC      = 2'd1,
    REQ_RD_PC_LT   = 2'd2,
    REQ_RD_INST_LT = 2'd3
  } req_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2,
    WAIT_RD = 2'd3
  } seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // read request codes 1..3 map onto the consecutive opcodes PC, PC_LT, INST_LT
  function automatic int unsigned rd_opcode(input req_op_e op);
    return OPC_PC + int'(op) - 1;
  endfunction

endpackage

// File: rtl/debug_cmd_sequencer_phase_counter.sv
// dbg_phase_counter: loadable down-counter that stops at zero and flags terminal count
module dbg_phase_counter #(
  parameter int CW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  // load on phase entry, otherwise count down and park at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (r_count != '0) r_count <= r_count - CW'(1);
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: turns write/read requests into timed command strobes for the debug receiver
module debug_cmd_sequencer
  import debug_cmd_sequencer_pkg::*;
#(
  parameter int NB_BITS  = 32,
  parameter int NB_DATA  = 16,
  parameter int NB_ADDR  = 10,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 2,
  parameter int RD_LAT   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [1:0]         i_req_op,
  input  logic [NB_ADDR-1:0] i_req_addr,
  input  logic [NB_BITS-1:0] i_req_data,
  output logic [NB_BITS-1:0] o_cmd,
  output logic               o_cmd_valid,
  input  logic [NB_BITS-1:0] i_dbg_data,
  output logic [NB_BITS-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy
);

  localparam int NB_OPC = NB_BITS - NB_DATA;
  localparam int CW     = $clog2(max3(HOLD_CYC, GAP_CYC, RD_LAT) + 1);

  seq_state_e         r_state, w_state;
  req_op_e            r_op, w_src_op;
  logic [NB_ADDR-1:0] r_addr, w_src_addr;
  logic [NB_BITS-1:0] r_data, w_src_data;
  logic [NB_BITS-1:0] r_cmd, r_rd_data;
  logic [1:0]         r_idx, w_src_idx;
  logic               r_rd_valid;
  logic               w_accept, w_next_cmd, w_sample, w_load, w_tc;
  logic [CW-1:0]      w_load_val;
  logic [NB_OPC-1:0]  w_opc;
  logic [NB_DATA-1:0] w_payload;

  dbg_phase_counter #(.CW(CW)) u_phase (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state;
  end

  // next state, phase counter loads and command/sample strobes
  always_comb begin
    w_state    = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_accept   = 1'b0;
    w_next_cmd = 1'b0;
    w_sample   = 1'b0;
    case (r_state)
      IDLE: if (i_req_valid) begin
        w_state    = SEND_HI;
        w_load     = 1'b1;
        w_load_val = CW'(HOLD_CYC - 1);
        w_accept   = 1'b1;
      end
      SEND_HI: if (w_tc) begin
        w_state    = SEND_LO;
        w_load     = 1'b1;
        w_load_val = CW'(GAP_CYC - 1);
      end
      SEND_LO: if (w_tc) begin
        if (r_op != REQ_WRITE) begin
          w_state    = WAIT_RD;
          w_load     = 1'b1;
          w_load_val = CW'(RD_LAT - 1);
        end else if (r_idx == 2'(N_WR_CMDS - 1)) begin
          w_state = IDLE;
        end else begin
          w_state    = SEND_HI;
          w_load     = 1'b1;
          w_load_val = CW'(HOLD_CYC - 1);
          w_next_cmd = 1'b1;
        end
      end
      WAIT_RD: if (w_tc) begin
        w_state  = IDLE;
        w_sample = 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end

  // build the command about to be emitted; on acceptance it comes straight from the request inputs
  always_comb begin
    w_src_op   = w_accept ? req_op_e'(i_req_op) : r_op;
    w_src_addr = w_accept ? i_req_addr : r_addr;
    w_src_data = w_accept ? i_req_data : r_data;
    w_src_idx  = w_accept ? 2'd0 : r_idx + 2'd1;
    w_opc      = (w_src_op != REQ_WRITE) ? NB_OPC'(rd_opcode(w_src_op)) :
                 (w_src_idx == 2'd0)     ? NB_OPC'(OPC_ADDR) :
                 (w_src_idx == 2'd1)     ? NB_OPC'(OPC_LDATA) :
                 (w_src_idx == 2'd2)     ? NB_OPC'(OPC_HDATA) : NB_OPC'(OPC_NOP);
    w_payload  = (w_src_op != REQ_WRITE) ? '0 :
                 (w_src_idx == 2'd0)     ? NB_DATA'(w_src_addr) :
                 (w_src_idx == 2'd1)     ? w_src_data[NB_DATA-1:0] :
                 (w_src_idx == 2'd2)     ? NB_DATA'(w_src_data[NB_BITS-1:NB_DATA]) : '0;
  end

  // request capture, command register (changes only on SEND_HI entry) and readback capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= REQ_WRITE;
      r_addr     <= '0;
      r_data     <= '0;
      r_idx      <= '0;
      r_cmd      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= w_src_op;
        r_addr <= i_req_addr;
        r_data <= i_req_data;
      end
      if (w_accept || w_next_cmd) begin
        r_idx <= w_src_idx;
        r_cmd <= {w_opc, w_payload};
      end
      if (w_sample) r_rd_data <= i_dbg_data;
      r_rd_valid <= w_sample;
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_busy      = ~o_req_ready;
  assign o_cmd_valid = (r_state == SEND_HI);
  assign o_cmd       = r_cmd;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb_debug_cmd_sequencer: directed and random requests against a timeline model of the command sequencer
module tb_debug_cmd_sequencer;

  localparam int HC[2] = '{2, 1};
  localparam int GC[2] = '{2, 1};
  localparam int RC[2] = '{2, 1};

  logic        clk;
  logic        rst_n;
  logic        req_valid[2];
  logic        req_ready[2];
  logic [1:0]  req_op[2];
  logic [9:0]  req_addr[2];
  logic [31:0] req_data[2];
  logic [31:0] cmd[2];
  logic        cmd_valid[2];
  logic [31:0] dbg[2];
  logic [31:0] rd_data[2];
  logic        rd_valid[2];
  logic        busy[2];

  logic [31:0] last_cmd[2];
  logic [31:0] last_rd[2];
  int checks = 0;
  int errors = 0;

  debug_cmd_sequencer u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_op(req_op[0]), .i_req_addr(req_addr[0]), .i_req_data(req_data[0]),
    .o_cmd(cmd[0]), .o_cmd_valid(cmd_valid[0]), .i_dbg_data(dbg[0]),
    .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .o_busy(busy[0])
  );

  debug_cmd_sequencer #(.HOLD_CYC(1), .GAP_CYC(1), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_op(req_op[1]), .i_req_addr(req_addr[1]), .i_req_data(req_data[1]),
    .o_cmd(cmd[1]), .o_cmd_valid(cmd_valid[1]), .i_dbg_data(dbg[1]),
    .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .o_busy(busy[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check($sformatf("%s d%0d ready", tag, d), 32'(req_ready[d]), 32'd1);
    check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
    check($sformatf("%s d%0d cmd_valid", tag, d), 32'(cmd_valid[d]), 32'd0);
    check($sformatf("%s d%0d cmd", tag, d), cmd[d], last_cmd[d]);
    check($sformatf("%s d%0d rd_data", tag, d), rd_data[d], last_rd[d]);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_idle(d, "idle");
      check($sformatf("idle d%0d rd_valid", d), 32'(rd_valid[d]), 32'd0);
    end
  endtask

  // mode 0: quiet inputs while busy; 1: random input noise while busy; 2: keep valid high with op=3
  // entered in an IDLE cycle (cycle 0) and left in the first IDLE cycle after the request, unless aborted
  task automatic run_req(input int d, input logic [1:0] op, input logic [9:0] addr, input logic [31:0] data,
                         input int mode, input int abort_at, input bit rnd_dbg, input logic [31:0] dbgv);
    logic [31:0] cmds[4];
    logic [31:0] dbg_exp;
    logic [31:0] want_cmd, want_rd;
    int n, p, tot, k, ph;
    bit want_valid, want_ready, want_rdv;
    n = (op == 2'd0) ? 4 : 1;
    p = HC[d] + GC[d];
    tot = n * p + ((op == 2'd0) ? 0 : RC[d]);
    cmds[0] = (op == 2'd0) ? {16'h0001, 6'h00, addr} : {16'(op) + 16'd3, 16'h0000};
    cmds[1] = {16'h0002, data[15:0]};
    cmds[2] = {16'h0003, data[31:16]};
    cmds[3] = 32'h0;
    dbg_exp = last_rd[d];
    check($sformatf("accept d%0d ready", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_op[d] = op;
    req_addr[d] = addr;
    req_data[d] = data;
    @(posedge clk); #1;
    if (mode != 2) req_valid[d] = 1'b0;
    for (int c = 1; c <= tot + 1; c++) begin
      if (mode == 1) begin
        req_valid[d] = (c <= tot) ? 1'($urandom) : 1'b0;
        req_op[d] = 2'($urandom);
        req_addr[d] = 10'($urandom);
        req_data[d] = $urandom;
      end else if (mode == 2) begin
        req_op[d] = 2'd3;
      end
      dbg[d] = rnd_dbg ? $urandom : dbgv;
      if (c == tot && op != 2'd0) dbg_exp = dbg[d];
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("abort d%0d cmd_valid", d), 32'(cmd_valid[d]), 32'd0);
        check($sformatf("abort d%0d cmd", d), cmd[d], 32'h0);
        check($sformatf("abort d%0d rd_data", d), rd_data[d], 32'h0);
        check($sformatf("abort d%0d rd_valid", d), 32'(rd_valid[d]), 32'd0);
        req_valid[d] = 1'b0;
        last_cmd = '{32'h0, 32'h0};
        last_rd = '{32'h0, 32'h0};
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_idle(d, "after_abort");
        return;
      end
      k = (c - 1) / p;
      ph = (c - 1) % p;
      want_cmd = (c <= n * p) ? cmds[k] : cmds[n-1];
      want_valid = (c <= n * p) && (ph < HC[d]);
      want_ready = (c > tot);
      want_rdv = (op != 2'd0) && (c == tot + 1);
      want_rd = want_rdv ? dbg_exp : last_rd[d];
      check($sformatf("d%0d op%0d c%0d cmd", d, op, c), cmd[d], want_cmd);
      check($sformatf("d%0d op%0d c%0d cmd_valid", d, op, c), 32'(cmd_valid[d]), 32'(want_valid));
      check($sformatf("d%0d op%0d c%0d ready", d, op, c), 32'(req_ready[d]), 32'(want_ready));
      check($sformatf("d%0d op%0d c%0d busy", d, op, c), 32'(busy[d]), 32'(!want_ready));
      check($sformatf("d%0d op%0d c%0d rd_valid", d, op, c), 32'(rd_valid[d]), 32'(want_rdv));
      check($sformatf("d%0d op%0d c%0d rd_data", d, op, c), rd_data[d], want_rd);
      if (c <= tot) begin
        @(posedge clk); #1;
      end
    end
    last_cmd[d] = cmds[n-1];
    if (op != 2'd0) last_rd[d] = dbg_exp;
  endtask

  initial begin
    int d;
    clk = 1'b0;
    rst_n = 1'b0;
    req_valid = '{1'b0, 1'b0};
    req_op = '{2'd0, 2'd0};
    req_addr = '{10'd0, 10'd0};
    req_data = '{32'd0, 32'd0};
    dbg = '{32'd0, 32'd0};
    last_cmd = '{32'h0, 32'h0};
    last_rd = '{32'h0, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_idle(i, "reset");
      check($sformatf("reset d%0d rd_valid", i), 32'(rd_valid[i]), 32'd0);
    end
    rst_n = 1'b1;
    idle(0, 1);
    run_req(0, 2'd0, 10'h005, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0);
    idle(0, 1);
    run_req(0, 2'd1, 10'h000, 32'h0, 0, 0, 1'b0, 32'h00000040);
    idle(0, 2);
    run_req(0, 2'd0, 10'h0A5, 32'h12345678, 2, 0, 1'b1, 32'h0);
    run_req(0, 2'd3, 10'h000, 32'h0, 0, 0, 1'b1, 32'h0);
    run_req(0, 2'd2, 10'h000, 32'h0, 0, 0, 1'b1, 32'h0);
    run_req(0, 2'd0, 10'h2C3, 32'hCAFEF00D, 1, 0, 1'b1, 32'h0);
    run_req(0, 2'd0, 10'h123, 32'h000055AA, 0, 6, 1'b1, 32'h0);
    run_req(0, 2'd0, 10'h3FF, 32'h00000001, 0, 0, 1'b1, 32'h0);
    idle(0, 1);
    run_req(1, 2'd2, 10'h000, 32'h0, 0, 0, 1'b0, 32'h13572468);
    idle(1, 1);
    run_req(1, 2'd0, 10'h011, 32'hA5A5C3C3, 1, 0, 1'b1, 32'h0);
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, 1));
      run_req(d, 2'($urandom), 10'($urandom), $urandom, int'($urandom_range(0, 1)), 0, 1'b1, 32'h0);
      if ($urandom_range(0, 1) == 1) idle(d, int'($urandom_range(1, 3)));
    end
    idle(0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_cmd_sequencer.md
DEBUG_CMD_SEQUENCER -- requirements
Module: debug_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: NB_BITS, default 32, command/data word width; NB_DATA, default 16, payload field width; NB_ADDR, default 10, memory address width; HOLD_CYC, default 2, cycles o_cmd_valid is high per command; GAP_CYC, default 2, cycles o_cmd_valid is low after each command; RD_LAT, default 2, wait cycles before readback sampling.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset: i_clk  in  1  clock, rising edge; i_rst_n  in  1  asynchronous active-low reset.
REQ-003 i_req_valid  in  1  request present.
REQ-004 o_req_ready  out  1  high only in IDLE; a request is accepted when i_req_valid and o_req_ready are both high at a rising edge.
REQ-005 i_req_op  in  2  request type: 0 write word, 1 read PC, 2 read latched PC, 3 read latched instruction.
REQ-006 i_req_addr  in  NB_ADDR  instruction-memory word address (write only).
REQ-007 i_req_data  in  NB_BITS  instruction word to write (write only).
REQ-008 o_cmd  out  NB_BITS  command word: [NB_BITS-1:NB_DATA] opcode, [NB_DATA-1:0] payload.
REQ-009 o_cmd_valid  out  1  command strobe; the receiver latches o_cmd on its rising edge.
REQ-010 i_dbg_data  in  NB_BITS  readback word from the debug receiver.
REQ-011 o_rd_data  out  NB_BITS  captured readback; o_rd_valid  out  1  one-cycle readback pulse; o_busy  out  1  inverse of o_req_ready.

Function
REQ-012 Opcodes SHALL be: NOP 0, ADDR 1, LDATA 2, HDATA 3, PC 4, PC_LT 5, INST_LT 6.
REQ-013 A write request SHALL emit four commands in order: {ADDR, zero-extended addr}, {LDATA, data[NB_DATA-1:0]}, {HDATA, data[NB_BITS-1:NB_DATA]}, {NOP, 0}. The NOP deasserts the receiver's write enable.
REQ-014 A read request SHALL emit one command {PC|PC_LT|INST_LT, 0} per i_req_op, with no trailing NOP.
REQ-015 Request fields SHALL be registered at acceptance; input changes while busy SHALL have no effect.
REQ-016 FSM states: IDLE, SEND_HI, SEND_LO, WAIT_RD. Transitions are IDLE->SEND_HI on accept; SEND_HI->SEND_LO after HOLD_CYC cycles; SEND_LO->SEND_HI (next command) or ->WAIT_RD (read) or ->IDLE (last write command) after GAP_CYC cycles; WAIT_RD->IDLE after RD_LAT cycles.
REQ-017 o_cmd_valid SHALL be high exactly in SEND_HI; o_cmd SHALL be stable throughout SEND_HI and SEND_LO of a command, and SHALL change only on entry to SEND_HI.
REQ-018 In IDLE, o_cmd SHALL hold its last value and o_cmd_valid SHALL be 0.
REQ-019 On the last WAIT_RD cycle, i_dbg_data SHALL be registered into o_rd_data; o_rd_valid SHALL pulse high for the next single cycle (the first IDLE cycle). o_rd_data SHALL hold until the next read.
REQ-020 Write timing with default parameters: accept at cycle 0, commands occupy cycles 1-16, and o_req_ready is high again at cycle 17.
REQ-021 Read timing with default parameters: accept at cycle 0; SEND_HI cycles 1-2; SEND_LO cycles 3-4; WAIT_RD cycles 5-6 with sampling at 6; o_rd_valid high at cycle 7.
REQ-022 A request pending during o_rd_valid SHALL be accepted in that same cycle, giving back-to-back operation without an idle gap.
REQ-023 Phase counters SHALL be ceil(log2(max(HOLD_CYC, GAP_CYC, RD_LAT)+1)) bits wide and count down without wraparound. Legal ranges are HOLD_CYC>=1, GAP_CYC>=1, RD_LAT>=1.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately force IDLE, o_cmd=0, o_cmd_valid=0, o_rd_data=0, o_rd_valid=0, o_req_ready=1 after release, and clear all counters, even mid-sequence. A write aborted mid-sequence is not retried.

Structure
REQ-025 Opcode constants and the i_req_op encoding SHALL live in the shared project include file, used by both this block and the debug receiver.
REQ-026 One sub-module, dbg_phase_counter, SHALL provide the loadable down-counter with a terminal-count flag used for the HOLD/GAP/RD_LAT phases.

Verification
REQ-027 Write addr 0x005, data 0xDEADBEEF: the bench SHALL see o_cmd 0x00010005, 0x0002BEEF, 0x0003DEAD, 0x00000000, each with valid high for 2 cycles then low for 2, and ready at cycle 17.
REQ-028 Read PC with i_dbg_data=0x00000040: the bench SHALL see o_cmd 0x00040000, then o_rd_valid high only at cycle 7 with o_rd_data=0x00000040.
REQ-029 Hold i_req_valid high with op=3 during a write: the bench SHALL see no acceptance until cycle 17, then INST_LT command 0x00060000.
REQ-030 Assert i_rst_n low in cycle 6 of a write: the bench SHALL see o_cmd_valid=0 and o_cmd=0 immediately, then a clean write of addr 0x3FF, data 0x00000001 after release giving 0x000103FF, 0x00020001, 0x00030000, 0x00000000.
REQ-031 Change i_req_addr/i_req_data during a write: the bench SHALL see the emitted commands reflect only the values captured at acceptance.
REQ-032 With HOLD_CYC=1, GAP_CYC=1, RD_LAT=1, read PC_LT: the bench SHALL see o_rd_valid at cycle 4 and the command 0x00050000.
